// File: rtl/hps_reset_pkg.sv
// Shared types and constants for the HPS reset request generator.
// FSM state encoding, request indices and counter width.
package hps_reset_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_RST = 2'd2,
        HOLDOFF  = 2'd3
    } state_t;

    localparam int COLD  = 0;
    localparam int WARM  = 1;
    localparam int DEBUG = 2;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/hps_reset_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Flops clear to 0 under synchronous reset.
module hps_reset_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the async level through two flops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/hps_reset_req_gen.sv
// FPGA-to-HPS reset request generator: edge-triggered cold/warm/debug
// requests, timed pulse, HPS handshake wait with timeout, and holdoff.
module hps_reset_req_gen
    import hps_reset_pkg::*;
#(
    parameter int PULSE_CYCLES   = 32,
    parameter int WAIT_CYCLES    = 65535,
    parameter int HOLDOFF_CYCLES = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [2:0]  req_source,
    input  logic        h2f_reset_n,
    output logic        f2h_cold_reset_req_n,
    output logic        f2h_warm_reset_req_n,
    output logic        f2h_debug_reset_req_n,
    output logic        busy,
    output logic        timeout,
    output logic [27:0] stm_hwevents
);

    localparam cnt_t PULSE_LD = cnt_t'(PULSE_CYCLES - 1);
    localparam cnt_t WAIT_LD  = cnt_t'(WAIT_CYCLES - 1);
    localparam cnt_t HOLD_LD  = cnt_t'(HOLDOFF_CYCLES - 1);

    logic       h2f_sync;
    logic [2:0] req_dly_q;
    logic [2:0] pend_q;
    logic [2:0] pend_d;
    logic [2:0] rise;
    logic [2:0] clr;
    logic [2:0] sel_oh;

    state_t     state_q;
    cnt_t       cnt_q;
    logic       dbg_q;
    logic       low_seen_q;
    logic [2:0] req_n_q;
    logic       busy_q;
    logic       timeout_q;
    logic [3:0] ev_q;

    hps_reset_sync2 u_sync (
        .clk_i (clk_clk),
        .rst_i (reset_reset),
        .d_i   (h2f_reset_n),
        .q_o   (h2f_sync)
    );

    // Priority select of the pending request and the flags it clears
    always_comb begin
        rise   = req_source & ~req_dly_q;
        sel_oh = 3'b000;
        clr    = 3'b000;
        if (state_q == IDLE) begin
            if (pend_q[COLD]) begin
                sel_oh = 3'b001;
                clr    = 3'b111;
            end else if (pend_q[WARM]) begin
                sel_oh = 3'b010;
                clr    = 3'b111;
            end else if (pend_q[DEBUG]) begin
                sel_oh = 3'b100;
                clr    = 3'b100;
            end
        end
        // A new edge in the clearing cycle survives
        pend_d = (pend_q & ~clr) | rise;
    end

    // Edge detector delay and pending flags
    always_ff @(posedge clk_clk) begin
        req_dly_q <= req_source;
        if (reset_reset) begin
            pend_q <= 3'b000;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Request FSM with shared down-counter and registered outputs
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dbg_q      <= 1'b0;
            low_seen_q <= 1'b0;
            req_n_q    <= 3'b111;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ev_q       <= 4'b0000;
        end else begin
            ev_q <= 4'b0000;
            unique case (state_q)
                IDLE: begin
                    if (sel_oh != 3'b000) begin
                        state_q <= ASSERT;
                        cnt_q   <= PULSE_LD;
                        dbg_q   <= sel_oh[DEBUG];
                        req_n_q <= ~sel_oh;
                        ev_q    <= {1'b0, sel_oh};
                        busy_q  <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (cnt_q == '0) begin
                        req_n_q    <= 3'b111;
                        low_seen_q <= 1'b0;
                        if (dbg_q) begin
                            state_q <= HOLDOFF;
                            cnt_q   <= HOLD_LD;
                        end else begin
                            state_q <= WAIT_RST;
                            cnt_q   <= WAIT_LD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WAIT_RST: begin
                    if (low_seen_q && h2f_sync) begin
                        state_q <= HOLDOFF;
                        cnt_q   <= HOLD_LD;
                    end else begin
                        if (!h2f_sync) begin
                            low_seen_q <= 1'b1;
                        end
                        if (cnt_q == '0) begin
                            state_q   <= HOLDOFF;
                            cnt_q     <= HOLD_LD;
                            timeout_q <= 1'b1;
                            ev_q[3]   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign f2h_cold_reset_req_n  = req_n_q[COLD];
    assign f2h_warm_reset_req_n  = req_n_q[WARM];
    assign f2h_debug_reset_req_n = req_n_q[DEBUG];
    assign busy                  = busy_q;
    assign timeout               = timeout_q;
    assign stm_hwevents          = {24'h000000, ev_q};

endmodule

// File: tb/tb_hps_reset_req_gen.sv
// Directed bench for hps_reset_req_gen with PULSE=4, WAIT=100, HOLDOFF=8.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_hps_reset_req_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic        h2f_n;
    logic        cold_n;
    logic        warm_n;
    logic        dbg_n;
    logic        busy;
    logic        tmo;
    logic [27:0] stm;

    int total = 0;
    int bad   = 0;

    hps_reset_req_gen #(
        .PULSE_CYCLES   (4),
        .WAIT_CYCLES    (100),
        .HOLDOFF_CYCLES (8)
    ) dut (
        .clk_clk               (clk),
        .reset_reset           (rst),
        .req_source            (req),
        .h2f_reset_n           (h2f_n),
        .f2h_cold_reset_req_n  (cold_n),
        .f2h_warm_reset_req_n  (warm_n),
        .f2h_debug_reset_req_n (dbg_n),
        .busy                  (busy),
        .timeout               (tmo),
        .stm_hwevents          (stm)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cold_lo;
        int dbg_lo;
        int ev0;
        int viol;

        rst   = 1'b1;
        req   = 3'b000;
        h2f_n = 1'b1;
        step(3);
        check("rst_req_n", {29'd0, cold_n, warm_n, dbg_n}, 32'h7);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_timeout", {31'd0, tmo}, 32'h0);
        check("rst_stm", {4'd0, stm}, 32'h0);
        rst = 1'b0;
        step(3);

        // Warm handshake
        req = 3'b010;
        step(1);
        check("A_not_yet", {31'd0, warm_n}, 32'h1);
        step(1);
        check("A_warm_low", {31'd0, warm_n}, 32'h0);
        check("A_others_hi", {30'd0, cold_n, dbg_n}, 32'h3);
        check("A_ev_warm", {4'd0, stm}, 32'h2);
        check("A_busy", {31'd0, busy}, 32'h1);
        step(1);
        check("A_ev_once", {4'd0, stm}, 32'h0);
        step(2);
        check("A_warm_low4", {31'd0, warm_n}, 32'h0);
        step(1);
        check("A_warm_rel", {31'd0, warm_n}, 32'h1);
        check("A_wait_busy", {31'd0, busy}, 32'h1);
        step(3);
        h2f_n = 1'b0;
        step(10);
        h2f_n = 1'b1;
        step(10);
        check("A_hold_last", {31'd0, busy}, 32'h1);
        step(1);
        check("A_idle", {31'd0, busy}, 32'h0);
        check("A_no_tmo", {31'd0, tmo}, 32'h0);

        // Cold and debug edges together
        req     = 3'b111;
        cold_lo = 0;
        dbg_lo  = 0;
        ev0     = 0;
        for (int i = 1; i <= 35; i++) begin
            step(1);
            if (!cold_n) cold_lo++;
            if (!dbg_n) dbg_lo++;
            if (stm[0]) ev0++;
            if (i == 6) h2f_n = 1'b0;
            if (i == 10) h2f_n = 1'b1;
        end
        check("B_cold_len", cold_lo, 32'd4);
        check("B_no_debug", dbg_lo, 32'd0);
        check("B_ev_cold", ev0, 32'd1);
        check("B_idle", {31'd0, busy}, 32'h0);
        req = 3'b000;
        step(2);

        // Timeout with h2f_reset_n held high
        req = 3'b010;
        step(6);
        check("C_in_wait", {30'd0, busy, warm_n}, 32'h3);
        step(99);
        check("C_pre_tmo", {31'd0, tmo}, 32'h0);
        check("C_pre_ev", {4'd0, stm}, 32'h0);
        step(1);
        check("C_tmo", {31'd0, tmo}, 32'h1);
        check("C_ev_tmo", {4'd0, stm}, 32'h8);
        step(1);
        check("C_ev_once", {4'd0, stm}, 32'h0);
        check("C_sticky", {31'd0, tmo}, 32'h1);
        step(7);
        check("C_idle", {31'd0, busy}, 32'h0);

        // Debug edge during holdoff of a prior debug request
        req = 3'b100;
        step(3);
        req = 3'b000;
        step(2);
        check("D_dbg_low", {31'd0, dbg_n}, 32'h0);
        step(1);
        check("D_dbg_rel", {30'd0, busy, dbg_n}, 32'h3);
        step(2);
        req = 3'b100;
        step(6);
        check("D_idle", {30'd0, busy, dbg_n}, 32'h1);
        step(1);
        check("D_dbg_again", {31'd0, dbg_n}, 32'h0);
        check("D_ev_dbg", {4'd0, stm}, 32'h4);
        step(12);
        check("D_done", {31'd0, busy}, 32'h0);
        check("D_tmo_kept", {31'd0, tmo}, 32'h1);

        // Levels held high through reset release
        rst = 1'b1;
        req = 3'b111;
        step(3);
        rst  = 1'b0;
        viol = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if ({cold_n, warm_n, dbg_n} !== 3'b111 || busy !== 1'b0) viol++;
        end
        check("E_no_req", viol, 32'd0);
        check("E_tmo_clr", {31'd0, tmo}, 32'h0);

        // Reset in the second cycle of a cold pulse
        req = 3'b000;
        step(2);
        req = 3'b001;
        step(2);
        check("F_cold_low", {31'd0, cold_n}, 32'h0);
        check("F_ev_cold", {4'd0, stm}, 32'h1);
        step(1);
        rst = 1'b1;
        step(1);
        check("F_req_n", {29'd0, cold_n, warm_n, dbg_n}, 32'h7);
        check("F_busy", {31'd0, busy}, 32'h0);
        check("F_stm", {4'd0, stm}, 32'h0);
        check("F_tmo", {31'd0, tmo}, 32'h0);
        rst = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
